regfile_alu_datapath: RTL

Datapath stage that consumes the control FSM's outputs: 16×16-bit register file, two read muxes, and an ALU with a registered status-flag register. Each cycle it reads operands A and B, computes an ALU result, and writes it into every register whose `regControl` bit is set. It sits directly downstream of the control FSM, and its outputs feed the display/debug logic.

---
 rtl/regfile_alu_datapath_if.sv | 33 +++
 rtl/regfile_alu_datapath.sv | 98 +++++++++
 2 files changed

// File: rtl/regfile_alu_datapath_if.sv
// regfile_alu_datapath_if: control/status bundle between the control FSM and the datapath
// Ports (signals):
//   regControl  per-register write enables (bit i writes R[i], multi-hot allowed)
//   regACont    operand A read select
//   regBCont    operand B read select
//   AluOp       ALU operation code
//   dbgSel      debug read select
//   result      combinational ALU output
//   wbData      registered copy of the last value written back
//   flags       registered {C, F, Z, N}
//   illegalOp   registered, high the cycle after a write cycle with an undefined opcode
//   dbgData     combinational R[dbgSel]
// Modports: master drives the controls (FSM side), slave is the datapath.
interface regfile_alu_datapath_if #(parameter int WIDTH = 16);
    logic [15:0]      regControl;
    logic [3:0]       regACont;
    logic [3:0]       regBCont;
    logic [7:0]       AluOp;
    logic [3:0]       dbgSel;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] wbData;
    logic [3:0]       flags;
    logic             illegalOp;
    logic [WIDTH-1:0] dbgData;
    modport master (
        output regControl, regACont, regBCont, AluOp, dbgSel,
        input  result, wbData, flags, illegalOp, dbgData
    );
    modport slave (
        input  regControl, regACont, regBCont, AluOp, dbgSel,
        output result, wbData, flags, illegalOp, dbgData
    );
endinterface

// File: rtl/regfile_alu_datapath.sv
// regfile_alu_datapath: 16x16 register file, two read muxes, ALU and registered status flags
// Ports:
//   clock  rising-edge system clock
//   Reset  asynchronous active-low reset
//   bus    regfile_alu_datapath_if.slave (controls in; result/wbData/flags/illegalOp/dbgData out)
module regfile_alu_datapath #(
    parameter int WIDTH = 16
) (
    input logic                 clock,
    input logic                 Reset,
    regfile_alu_datapath_if.slave bus
);
    localparam logic [WIDTH:0] ONE = 1;
    logic [WIDTH-1:0] r [16];
    logic [WIDTH-1:0] a, b, res, wb_q;
    logic [WIDTH:0]   sum, dif, inc, dec, lw, rw, aw;
    logic [3:0]       s, flags_q;
    logic             c, f, legal, ill_q, we;
    assign a  = r[bus.regACont];
    assign b  = r[bus.regBCont];
    assign s  = b[3:0];
    assign we = |bus.regControl;
    always_comb begin
        // 17-bit forms expose carry/borrow in the top bit
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        inc = {1'b0, a} + ONE;
        dec = {1'b0, a} - ONE;
        // one guard bit beyond the data catches the last bit shifted out; shift by 0 leaves it 0
        lw  = {1'b0, a} << s;
        rw  = {a, 1'b0} >> s;
        aw  = $signed({a, 1'b0}) >>> s;
        res   = '0;
        c     = 1'b0;
        f     = 1'b0;
        legal = 1'b1;
        case (bus.AluOp)
            8'h00: res = a;
            8'h01: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                f   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            8'h02: begin
                res = dif[WIDTH-1:0];
                c   = dif[WIDTH];
                f   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            8'h03: res = a & b;
            8'h04: res = a | b;
            8'h05: res = a ^ b;
            8'h06: res = ~a;
            8'h07: begin
                res = inc[WIDTH-1:0];
                c   = inc[WIDTH];
                f   = !a[WIDTH-1] && res[WIDTH-1];
            end
            8'h08: begin
                res = dec[WIDTH-1:0];
                c   = dec[WIDTH];
                f   = a[WIDTH-1] && !res[WIDTH-1];
            end
            8'h11: begin
                res = lw[WIDTH-1:0];
                c   = lw[WIDTH];
            end
            8'h12: begin
                res = rw[WIDTH:1];
                c   = rw[0];
            end
            8'h13: begin
                res = aw[WIDTH:1];
                c   = aw[0];
            end
            default: legal = 1'b0;
        endcase
    end
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            wb_q    <= '0;
            flags_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            ill_q <= we && !legal;
            if (we && legal) begin
                for (int i = 0; i < 16; i++) if (bus.regControl[i]) r[i] <= res;
                wb_q    <= res;
                flags_q <= {c, f, res == '0, res[WIDTH-1]};
            end
        end
    end
    assign bus.result    = res;
    assign bus.wbData    = wb_q;
    assign bus.flags     = flags_q;
    assign bus.illegalOp = ill_q;
    assign bus.dbgData   = r[bus.dbgSel];
endmodule
